// File: rtl/lram_pkg.sv
// lram_pkg: shared constants and the read-tag type for the local RAM arbiter.
package lram_pkg;

    localparam int LRAM_AW     = 10;
    localparam int LRAM_DW     = 32;
    localparam int LRAM_RD_LAT = 3;

    localparam logic PORT_HOST = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } lram_tag_t;

endpackage

// File: rtl/lram_tagpipe.sv
// lram_tagpipe: read-tag delay line matching the RAM read latency; the oldest
// stage steers the rvalid pulse back to the port that issued the read.
module lram_tagpipe
    import lram_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tag_valid_i,
    input  logic tag_port_i,
    output logic p0_rvalid_o,
    output logic p1_rvalid_o
);

    lram_tag_t [LRAM_RD_LAT-1:0] tag_q, tag_d;

    always_comb begin
        tag_d = {tag_q[LRAM_RD_LAT-2:0], tag_valid_i, tag_port_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            tag_q <= '0;
        else
            tag_q <= tag_d;
    end

    assign p0_rvalid_o = tag_q[LRAM_RD_LAT-1].valid & (tag_q[LRAM_RD_LAT-1].port == PORT_HOST);
    assign p1_rvalid_o = tag_q[LRAM_RD_LAT-1].valid & (tag_q[LRAM_RD_LAT-1].port == PORT_DMA);

endmodule

// File: rtl/lram_arb2.sv
// lram_arb2: two-port arbiter for the single-port local RAM; host has fixed
// priority, a starvation counter forces a DMA grant, read results return in order.
module lram_arb2
    import lram_pkg::*;
#(
    parameter int AW         = LRAM_AW,
    parameter int DW         = LRAM_DW,
    parameter int STARVE_LIM = 8
) (
    input  logic          sys_clk,
    input  logic          resetl,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_a,
    input  logic [DW-1:0] p0_d,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_a,
    input  logic [DW-1:0] p1_d,
    output logic          p0_gnt,
    output logic          p1_gnt,
    output logic          p0_rvalid,
    output logic          p1_rvalid,
    output logic [DW-1:0] rdata,
    output logic          ram_cs_n,
    output logic          ram_we_n,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    logic          force1, p0_acc, p1_acc, acc, acc_we, push_valid, push_port;
    logic [7:0]    starve_q, starve_d;
    logic          cs_n_q, cs_n_d, we_n_q, we_n_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] din_q, din_d;

    assign force1 = (starve_q == 8'(STARVE_LIM));
    assign p0_gnt = p0_req & ~force1;
    assign p1_gnt = p1_req & (~p0_req | force1);

    always_comb begin
        p0_acc     = p0_req & p0_gnt;
        p1_acc     = p1_req & p1_gnt;
        acc        = p0_acc | p1_acc;
        acc_we     = p1_acc ? p1_we : p0_we;
        // Counter only runs while port 1 is actually waiting; it parks at the limit.
        starve_d   = (~p1_req | p1_acc) ? 8'd0 : (force1 ? starve_q : starve_q + 8'd1);
        cs_n_d     = ~acc;
        we_n_d     = ~(acc & acc_we);
        a_d        = acc ? (p1_acc ? p1_a : p0_a) : a_q;
        din_d      = acc ? (p1_acc ? p1_d : p0_d) : din_q;
        push_valid = acc & ~acc_we;
        push_port  = p1_acc ? PORT_DMA : PORT_HOST;
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            starve_q <= '0;
            cs_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            a_q      <= '0;
            din_q    <= '0;
        end else begin
            starve_q <= starve_d;
            cs_n_q   <= cs_n_d;
            we_n_q   <= we_n_d;
            a_q      <= a_d;
            din_q    <= din_d;
        end
    end

    lram_tagpipe u_tagpipe (
        .clk_i       (sys_clk),
        .rst_ni      (resetl),
        .tag_valid_i (push_valid),
        .tag_port_i  (push_port),
        .p0_rvalid_o (p0_rvalid),
        .p1_rvalid_o (p1_rvalid)
    );

    assign ram_cs_n = cs_n_q;
    assign ram_we_n = we_n_q;
    assign ram_a    = a_q;
    assign ram_din  = din_q;
    assign rdata    = ram_dout;

endmodule

// File: tb/tb_lram_arb2.sv
// tb_lram_arb2: directed bench for lram_arb2 with a two-cycle registered RAM model.
module tb_lram_arb2;

    logic        sys_clk = 1'b0;
    logic        resetl;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [9:0]  p0_a, p1_a, ram_a;
    logic [31:0] p0_d, p1_d, ram_din, ram_dout, rdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_cs_n, ram_we_n;
    logic [31:0] mem [1024];
    logic [31:0] rd1;
    int          passed = 0, total = 0;

    typedef struct {
        logic r0, w0, r1, w1;
        logic [9:0]  a0, a1;
        logic [31:0] d0, d1;
        logic g0, g1, cs_n, we_n;
        logic [9:0]  ea;
        logic [31:0] ed;
        logic rv0, rv1;
        logic [31:0] erd;
    } vec_t;

    vec_t v [8];

    always #5 sys_clk = ~sys_clk;

    lram_arb2 #(.AW(10), .DW(32), .STARVE_LIM(8)) dut (
        .sys_clk   (sys_clk),
        .resetl    (resetl),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_a      (p0_a),
        .p0_d      (p0_d),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_a      (p1_a),
        .p1_d      (p1_d),
        .p0_gnt    (p0_gnt),
        .p1_gnt    (p1_gnt),
        .p0_rvalid (p0_rvalid),
        .p1_rvalid (p1_rvalid),
        .rdata     (rdata),
        .ram_cs_n  (ram_cs_n),
        .ram_we_n  (ram_we_n),
        .ram_a     (ram_a),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // RAM model: prefilled with mem[i] = i * 0x01010101, read data two edges after the strobe.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h01010101;
        rd1 = '0;
        ram_dout = '0;
        forever begin
            @(posedge sys_clk);
            ram_dout = rd1;
            if (!ram_cs_n) begin
                if (!ram_we_n) mem[ram_a] = ram_din;
                else rd1 = mem[ram_a];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic step;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic mid;
        @(negedge sys_clk);
    endtask

    task automatic idle;
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        p0_a = '0; p1_a = '0; p0_d = '0; p1_d = '0;
    endtask

    initial begin
        v[0] = '{1'b1,1'b1,1'b0,1'b0,10'h005,10'h000,32'h12345678,32'h0, 1'b1,1'b0,1'b0,1'b0,10'h005,32'h12345678,1'b0,1'b0,32'h0};
        v[1] = '{1'b1,1'b0,1'b0,1'b0,10'h005,10'h000,32'hAAAA0000,32'h0, 1'b1,1'b0,1'b0,1'b1,10'h005,32'hAAAA0000,1'b1,1'b0,32'h12345678};
        v[2] = '{1'b0,1'b0,1'b1,1'b0,10'h000,10'h003,32'h0,32'h0, 1'b0,1'b1,1'b0,1'b1,10'h003,32'h0,1'b0,1'b1,32'h03030303};
        v[3] = '{1'b1,1'b0,1'b1,1'b1,10'h007,10'h008,32'h11111111,32'h55, 1'b1,1'b0,1'b0,1'b1,10'h007,32'h11111111,1'b1,1'b0,32'h07070707};
        v[4] = '{1'b0,1'b0,1'b0,1'b0,10'h000,10'h000,32'h0,32'h0, 1'b0,1'b0,1'b1,1'b1,10'h007,32'h11111111,1'b0,1'b0,32'h0};
        v[5] = '{1'b0,1'b0,1'b1,1'b1,10'h000,10'h3FF,32'h0,32'hDEADBEEF, 1'b0,1'b1,1'b0,1'b0,10'h3FF,32'hDEADBEEF,1'b0,1'b0,32'h0};
        v[6] = '{1'b0,1'b0,1'b1,1'b0,10'h000,10'h3FF,32'h0,32'h0, 1'b0,1'b1,1'b0,1'b1,10'h3FF,32'h0,1'b0,1'b1,32'hDEADBEEF};
        v[7] = '{1'b1,1'b1,1'b1,1'b0,10'h010,10'h001,32'hCAFEF00D,32'h0, 1'b1,1'b0,1'b0,1'b0,10'h010,32'hCAFEF00D,1'b0,1'b0,32'h0};

        idle;
        resetl = 1'b1;
        #1 resetl = 1'b0;
        p0_req = 1;

        // Reset values; grants follow requests even in reset.
        mid;
        chk("rst_p0_gnt", p0_gnt, 1);
        chk("rst_p1_gnt", p1_gnt, 0);
        chk("rst_cs_n", ram_cs_n, 1);
        chk("rst_we_n", ram_we_n, 1);
        chk("rst_a", ram_a, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_rv0", p0_rvalid, 0);
        chk("rst_rv1", p1_rvalid, 0);
        step; p0_req = 0; p1_req = 1;
        mid;
        chk("rst_p1_gnt_req", p1_gnt, 1);
        step; idle; resetl = 1'b1;
        mid;
        chk("rst_dropped_cs_n", ram_cs_n, 1);

        // Write then read the top address from port 0.
        step; p0_req = 1; p0_we = 1; p0_a = 10'h3FF; p0_d = 32'hDEADBEEF;
        mid; chk("a_gnt_w", p0_gnt, 1);
        step; p0_we = 0;
        mid; chk("a_gnt_r", p0_gnt, 1); chk("a_cs_w", ram_cs_n, 0); chk("a_we_w", ram_we_n, 0);
        chk("a_a_w", ram_a, 10'h3FF); chk("a_din_w", ram_din, 32'hDEADBEEF);
        step; idle;
        mid; chk("a_cs_r", ram_cs_n, 0); chk("a_we_r", ram_we_n, 1); chk("a_a_r", ram_a, 10'h3FF);
        step;
        mid; chk("a_cs_off", ram_cs_n, 1); chk("a_rv0_early", p0_rvalid, 0);
        step;
        mid; chk("a_rv0", p0_rvalid, 1); chk("a_rdata", rdata, 32'hDEADBEEF); chk("a_rv1", p1_rvalid, 0);
        step;
        mid; chk("a_rv0_after", p0_rvalid, 0); chk("a_cs_idle", ram_cs_n, 1);

        // Streaming port 1 reads of addresses 0..15.
        for (int k = 0; k < 20; k++) begin
            step; idle;
            p1_req = (k < 16); p1_a = 10'(k);
            mid;
            if (k < 16) chk("s_gnt", p1_gnt, 1);
            if (k >= 3 && k < 19) begin
                chk("s_rv1", p1_rvalid, 1);
                chk("s_rdata", rdata, 32'(k - 3) * 32'h01010101);
            end else chk("s_rv1_idle", p1_rvalid, 0);
            chk("s_rv0", p0_rvalid, 0);
        end

        // Both ports requesting continuously: port 1 forced every 9th cycle.
        for (int c = 0; c < 27; c++) begin
            step; p0_req = 1; p1_req = 1; p0_a = 10'h020; p1_a = 10'h021;
            mid;
            chk("p_gnt1", p1_gnt, (c % 9) == 8);
            chk("p_gnt0", p0_gnt, (c % 9) != 8);
        end
        step; idle;
        repeat (4) step;

        // Dropping p1_req clears the count: forced grant 8 cycles after reassertion.
        for (int c = 0; c < 16; c++) begin
            step; p0_req = 1; p1_req = (c != 5); p0_a = 10'h030; p1_a = 10'h031;
            mid;
            chk("sc_gnt1", p1_gnt, c == 14);
            chk("sc_gnt0", p0_gnt, c != 14);
        end
        step; idle;
        repeat (4) step;

        // Interleaved p0 read / p1 read / p0 write.
        for (int c = 0; c < 13; c++) begin
            int o;
            step; idle;
            if (c < 9) begin
                if (c % 3 == 0) begin p0_req = 1; p0_a = 10'(c); end
                else if (c % 3 == 1) begin p1_req = 1; p1_a = 10'(c); end
                else begin p0_req = 1; p0_we = 1; p0_a = 10'h100 + 10'(c); p0_d = 32'hF00D0000 | 32'(c); end
            end
            mid;
            if (c < 9) chk("m_gnt", (c % 3 == 1) ? p1_gnt : p0_gnt, 1);
            o = c - 3;
            chk("m_rv0", p0_rvalid, o >= 0 && o < 9 && o % 3 == 0);
            chk("m_rv1", p1_rvalid, o >= 0 && o < 9 && o % 3 == 1);
            if (o >= 0 && o < 9 && o % 3 != 2) chk("m_rdata", rdata, 32'(o) * 32'h01010101);
        end

        // Vector table: single accesses with command and return checks.
        foreach (v[i]) begin
            step;
            p0_req = v[i].r0; p0_we = v[i].w0; p0_a = v[i].a0; p0_d = v[i].d0;
            p1_req = v[i].r1; p1_we = v[i].w1; p1_a = v[i].a1; p1_d = v[i].d1;
            mid;
            chk($sformatf("v%0d_gnt0", i), p0_gnt, v[i].g0);
            chk($sformatf("v%0d_gnt1", i), p1_gnt, v[i].g1);
            step; idle;
            mid;
            chk($sformatf("v%0d_cs_n", i), ram_cs_n, v[i].cs_n);
            chk($sformatf("v%0d_we_n", i), ram_we_n, v[i].we_n);
            chk($sformatf("v%0d_a", i), ram_a, v[i].ea);
            chk($sformatf("v%0d_din", i), ram_din, v[i].ed);
            step; step;
            mid;
            chk($sformatf("v%0d_rv0", i), p0_rvalid, v[i].rv0);
            chk($sformatf("v%0d_rv1", i), p1_rvalid, v[i].rv1);
            if (v[i].rv0 | v[i].rv1) chk($sformatf("v%0d_rdata", i), rdata, v[i].erd);
        end

        // Reset with two reads in flight.
        step; p0_req = 1; p0_a = 10'h001;
        mid; chk("r_gnt_a", p0_gnt, 1);
        step; p0_a = 10'h002;
        mid; chk("r_gnt_b", p0_gnt, 1);
        step; idle;
        chk("r_cs_before", ram_cs_n, 0);
        resetl = 1'b0;
        #1 chk("r_cs_async", ram_cs_n, 1);
        step; resetl = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mid;
            chk("r_rv0_flushed", p0_rvalid, 0);
            chk("r_rv1_flushed", p1_rvalid, 0);
            step;
        end
        p0_req = 1; p0_a = 10'h004;
        mid; chk("r_gnt_new", p0_gnt, 1);
        step; idle;
        step; step;
        mid; chk("r_rv0_new", p0_rvalid, 1); chk("r_rdata_new", rdata, 32'h04040404);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
